// File: rtl/skolem_tt_capture.sv
// Truth-table capture harness around a combinational Skolem block: sweeps all
// 2^IN_W input vectors and streams the results out one byte at a time.
// Optional CRC-8 signature port when SKOLEM_TT_CRC_EN is defined.
module skolem_tt_capture #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic [IN_W-1:0] sk_in,
  input  logic            sk_out,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [IN_W:0]   ones_cnt,
  output logic            done
`ifdef SKOLEM_TT_CRC_EN
  ,
  output logic [7:0]      crc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_EMIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0] sk_in_q, sk_in_d;
  logic [7:0]      shift_q, shift_d;
  logic [IN_W:0]   ones_q, ones_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            start_acc;
  logic            hs;

  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
  assign hs        = (state_q == S_EMIT) && valid_q && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SWEEP;
      S_SWEEP: if (idx_q[2:0] == 3'd7) state_d = S_EMIT;
      S_EMIT:  if (hs) state_d = last_q ? S_DONE : S_SWEEP;
      S_DONE:  if (start) state_d = S_SWEEP;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output next values. sk_in only advances while staying in SWEEP,
  // so during EMIT it keeps showing the last vector sampled.
  always_comb begin
    idx_d   = idx_q;
    sk_in_d = sk_in_q;
    shift_d = shift_q;
    ones_d  = ones_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d   = '0;
          sk_in_d = '0;
          shift_d = '0;
          ones_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_SWEEP: begin
        shift_d[idx_q[2:0]] = sk_out;
        ones_d = ones_q + {{IN_W{1'b0}}, sk_out};
        idx_d  = idx_q + 1'b1;
        if (idx_q[2:0] == 3'd7) begin
          data_d  = shift_d;
          valid_d = 1'b1;
          last_d  = &idx_q;
        end else begin
          sk_in_d = idx_d;
        end
      end
      S_EMIT: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            sk_in_d = idx_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      sk_in_q <= '0;
      shift_q <= '0;
      ones_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sk_in_q <= sk_in_d;
      shift_q <= shift_d;
      ones_q  <= ones_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign sk_in     = sk_in_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign ones_cnt  = ones_q;
  assign done      = done_q;

`ifdef SKOLEM_TT_CRC_EN
  logic [7:0] crc_q, crc_d;

  // CRC-8 poly 0x07, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h07;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (start_acc) crc_d = 8'h00;
    else if (hs)   crc_d = crc8_byte(crc_q, data_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 8'h00;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;
`endif

endmodule

// File: tb/tb_skolem_tt_capture.sv
// Directed bench for skolem_tt_capture: stub and golden Skolem functions,
// backpressure, mid-sweep reset and ignored start pulses.
module tb_skolem_tt_capture;
  localparam int IN_W = 8;
  localparam int NBYTES = (1 << IN_W) / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic [IN_W-1:0] sk_in;
  logic            sk_out;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic [IN_W:0]   ones_cnt;
  logic            done;
`ifdef SKOLEM_TT_CRC_EN
  logic [7:0]      crc;
`endif

  int checks = 0;
  int errors = 0;
  int mode = 0;

  logic [7:0] got [NBYTES];
  logic       lst [NBYTES];
  int         nb;
  logic       done_seen;
  logic [7:0] ref_d;
  logic       ref_l;
  logic [7:0] ref_s;
  logic [7:0] exp_crc;

  skolem_tt_capture #(.IN_W(IN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .sk_in(sk_in),
    .sk_out(sk_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .ones_cnt(ones_cnt), .done(done)
`ifdef SKOLEM_TT_CRC_EN
    , .crc(crc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic gold(input logic [7:0] v);
    return (v[0] & v[3]) ^ (v[5] | ~v[2]) ^ (v[7] & v[6] & ~v[1]) ^ v[4];
  endfunction

  always_comb begin
    case (mode)
      1:       sk_out = sk_in[0];
      2:       sk_out = sk_in[IN_W-1];
      3:       sk_out = gold(sk_in);
      default: sk_out = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_sk_in"}, 32'(sk_in), 0);
    chk({p, "_out_data"}, 32'(out_data), 0);
    chk({p, "_out_valid"}, 32'(out_valid), 0);
    chk({p, "_out_last"}, 32'(out_last), 0);
    chk({p, "_ones_cnt"}, 32'(ones_cnt), 0);
    chk({p, "_done"}, 32'(done), 0);
`ifdef SKOLEM_TT_CRC_EN
    chk({p, "_crc"}, 32'(crc), 0);
`endif
  endtask

  // Runs one sweep from IDLE/DONE; optional 5-cycle stall on one byte and
  // optional start pulses injected while busy.
  task automatic sweep(input int stall_byte, input bit inject, output int cyc, output int first_v);
    int stall_left;
    stall_left = 5;
    nb = 0;
    cyc = 0;
    first_v = -1;
    done_seen = 1'b0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 2000 && !done_seen) begin
      @(negedge clk);
      cyc++;
      start = inject && (cyc == 50 || cyc == 150);
      if (cyc == 1) chk("busy_in_sweep", 32'(busy), 1);
      if (done) done_seen = 1'b1;
      else if (out_valid) begin
        if (first_v < 0) first_v = cyc;
        if (nb == stall_byte && stall_left > 0) begin
          if (stall_left == 5) begin
            ref_d = out_data; ref_l = out_last; ref_s = sk_in;
            chk("stall_sk_in", 32'(sk_in), 32'(stall_byte * 8 + 7));
          end else begin
            chk("stall_data", 32'(out_data), 32'(ref_d));
            chk("stall_last", 32'(out_last), 32'(ref_l));
            chk("stall_sk_in_hold", 32'(sk_in), 32'(ref_s));
          end
          out_ready = 1'b0;
          stall_left--;
        end else begin
          if (nb == stall_byte) chk("stall_release_data", 32'(out_data), 32'(ref_d));
          out_ready = 1'b1;
          if (nb < NBYTES) begin
            got[nb] = out_data;
            lst[nb] = out_last;
          end
          nb++;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", 32'(done_seen), 1);
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = (r[7] ^ d[i]) ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Compares captured bytes and last flags to the expected table for a mode.
  task automatic check_bytes(input int m, input string p);
    logic [7:0] e;
    logic [7:0] v;
    exp_crc = 8'h00;
    chk({p, "_nbytes"}, 32'(nb), NBYTES);
    for (int b = 0; b < NBYTES; b++) begin
      case (m)
        1:       e = 8'hAA;
        2:       e = (b >= NBYTES / 2) ? 8'hFF : 8'h00;
        3: begin
          for (int j = 0; j < 8; j++) begin
            v = 8'(b * 8 + j);
            e[j] = gold(v);
          end
        end
        default: e = 8'h00;
      endcase
      exp_crc = crc_step(exp_crc, e);
      chk($sformatf("%s_byte%0d", p, b), 32'(got[b]), 32'(e));
      chk($sformatf("%s_last%0d", p, b), 32'(lst[b]), 32'(b == NBYTES - 1));
    end
  endtask

  initial begin
    int cyc;
    int fv;
    int cnt;
    int k;
    int pop;
    logic seen;
    logic [7:0] v8;

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // all-zero stub: 288 edges after the accept edge (cycle 290 counting the start cycle as 1)
    mode = 0;
    sweep(-1, 1'b0, cyc, fv);
    chk("zero_first_valid", 32'(fv), 8);
    chk("zero_done_cycle", 32'(cyc), 288);
    check_bytes(0, "zero");
    chk("zero_ones", 32'(ones_cnt), 0);
`ifdef SKOLEM_TT_CRC_EN
    chk("zero_crc", 32'(crc), 32'h00);
`endif
    @(negedge clk);
    chk("zero_done_pulse", 32'(done), 0);
    chk("zero_busy_done", 32'(busy), 0);

    // sk_in[0] stub with backpressure on byte 3
    mode = 1;
    sweep(3, 1'b0, cyc, fv);
    chk("lsb_done_cycle_stall", 32'(cyc), 293);
    check_bytes(1, "lsb");
    chk("lsb_ones", 32'(ones_cnt), 128);
`ifdef SKOLEM_TT_CRC_EN
    chk("lsb_crc", 32'(crc), 32'(exp_crc));
`endif

    // MSB stub
    mode = 2;
    sweep(-1, 1'b0, cyc, fv);
    chk("msb_done_cycle", 32'(cyc), 288);
    check_bytes(2, "msb");
    chk("msb_ones", 32'(ones_cnt), 128);

    // reset during byte 10
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    k = 0;
    while (cnt < 10 && k < 2000) begin
      @(negedge clk);
      k++;
      if (out_valid) cnt++;
    end
    chk("abort_bytes_before_reset", 32'(cnt), 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("abort_idle_quiet", 32'(seen), 0);
    sweep(-1, 1'b0, cyc, fv);
    chk("restart_done_cycle", 32'(cyc), 288);
    check_bytes(1, "restart");
    chk("restart_ones", 32'(ones_cnt), 128);

    // golden function with start pulses while busy
    mode = 3;
    pop = 0;
    for (int i = 0; i < (1 << IN_W); i++) begin
      v8 = 8'(i);
      pop += int'(gold(v8));
    end
    sweep(-1, 1'b1, cyc, fv);
    chk("gold_done_cycle", 32'(cyc), 288);
    check_bytes(3, "gold");
    chk("gold_ones", 32'(ones_cnt), 32'(pop));
`ifdef SKOLEM_TT_CRC_EN
    chk("gold_crc", 32'(crc), 32'(exp_crc));
`endif
    @(negedge clk);
    chk("gold_idle_after_done", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/skolem_tt_capture.md
# skolem_tt_capture

Sequential harness stage that sits directly around one combinational Skolem-function block (inputs i0..iN-1, output iN). It sweeps every input vector, drives the Skolem inputs, samples the Skolem output and packs the results into a byte-serial truth-table stream with a valid/ready handshake. It also keeps a population count of ones. It is the downstream consumer of the Skolem netlist, used for equivalence and regression checks of regenerated Skolem functions.

## Interface
Parameters:
- IN_W, 8, number of Skolem inputs; sweep length 2^IN_W vectors; legal range 3..12.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level sampled in IDLE and DONE; begins a sweep.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- sk_in  out  IN_W  registered drive to the Skolem block; sk_in[k] drives input ik.
- sk_out  in  1  Skolem block output, combinational from sk_in.
- out_data  out  8  truth-table byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_last  out  1  high with the final byte of a sweep.
- ones_cnt  out  IN_W+1  count of vectors with sk_out=1; valid in DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- crc  out  8  signature; present only with SKOLEM_TT_CRC_EN.

## Operation
- The FSM has four states: IDLE, SWEEP, EMIT, DONE.
- IDLE: start=1 clears idx, shift, ones_cnt and crc, then moves to SWEEP.
- SWEEP: sk_in = idx. At each clock edge sk_out is shifted into shift[idx[2:0]] and ones_cnt += sk_out.
  - When idx[2:0]==7, the cycle moves to EMIT, and idx is incremented either way.
- EMIT:
  - out_data = shift, out_valid=1, out_last = (idx wrapped to 0).
  - On handshake: if out_last, go to DONE; else go to SWEEP.
  - While stalled, sk_in, out_data and out_last hold stable.
- DONE: done pulses once and ones_cnt/crc hold. start=1 begins a new sweep, with clearing as in IDLE.
- Bit order: out_data[j] is the result for vector {byte_index, j[2:0]}. Bytes are emitted in ascending byte_index.
- sk_in holds the last driven vector outside SWEEP. It returns to 0 only on reset or on a new start.
- start while busy is ignored.
- ones_cnt never saturates: the maximum is 2^IN_W, which fits in IN_W+1 bits.

## Timing
- Reset values:
  - state IDLE, busy 0, sk_in 0, out_data 0, out_valid 0, out_last 0, ones_cnt 0, done 0, crc 0.
- Reset mid-sweep aborts immediately. No partial byte is emitted, and start is required to restart.
- Latency from start edge to the first out_valid is 9 cycles: 1 accept cycle plus 8 sample cycles.
- With out_ready tied high, each byte takes 9 cycles: 8 SWEEP plus 1 EMIT.
  - Full sweep for IN_W=8: 32 bytes, 288 cycles from first SWEEP to the last handshake.
  - done asserts the cycle after the last handshake.
- sk_out is sampled one full clock period after sk_in updates. The Skolem path needs only single-cycle combinational timing.
- out_valid, once high, stays high until handshake; data stays stable during stall.

## Configuration
- SKOLEM_TT_CRC_EN defined:
  - CRC-8 with polynomial 0x07, init 0x00, no reflection and no final XOR.
  - Computed over each byte at handshake, MSB first.
  - Final value on the crc port is stable in DONE and cleared by start.
- Not defined: the crc port and its logic are absent. All other behaviour is identical.

## Test plan
- Stub sk_out=0, IN_W=8, out_ready=1:
  - 32 bytes of 0x00, out_last only on byte 31, ones_cnt=0, done at cycle 290 after start, crc=0x00.
- Stub sk_out=sk_in[0]:
  - every byte 0xAA, ones_cnt=128.
- Stub sk_out=sk_in[IN_W-1]:
  - bytes 0..15 = 0x00, bytes 16..31 = 0xFF, ones_cnt=128.
- Backpressure: out_ready=0 for 5 cycles when byte 3 is presented.
  - out_data, out_last and sk_in hold stable; no byte is lost or duplicated.
  - Total cycles increase by exactly 5.
- Reset mid-sweep: rst_n low during byte 10 of a sweep.
  - All outputs return to reset values at once; no out_valid until a new start.
  - A new start then produces a full 32-byte sweep.
- Real Skolem netlist connected:
  - captured 256-bit table matches the golden table evaluated in the bench.
  - ones_cnt equals the golden popcount.
  - start pulses asserted during the sweep are ignored.
